uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Downstream consumer of the CPU's UART data-bus write strobe: captures each byte the CPU writes to the UART and queues it in a small FIFO.
- Serialises queued bytes onto a TX line as 8N1 frames, LSB first.
- Exports active-high status lines (tx_ready, tx_idle) that feed the spare inputs of the jump-logic multiplexer, so programs can poll them with conditional jumps instead of having them tied low.

Parameters:
- CLKS_PER_BIT, 16: i_clk cycles per serial bit (≥2).
- FIFO_DEPTH, 16: byte entries; power of two, ≥2.
- CNT_W, 5: fifo_count width; must equal log2(FIFO_DEPTH)+1.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  8  data-bus value to enqueue.
- wr_n  input  1  active-low write strobe (UARTread); one byte enqueued per rising edge with wr_n==0.
- clr_ovf  input  1  active-high; clears the overflow flag.
- txd  output  1  serial output; idle high.
- tx_ready  output  1  high when FIFO not full (fifo_count < FIFO_DEPTH).
- tx_idle  output  1  high when FIFO empty and FSM in IDLE.
- tx_busy  output  1  high when FSM not in IDLE.
- fifo_count  output  CNT_W  bytes queued, 0..FIFO_DEPTH; excludes the byte being shifted.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset==0, asynchronous, effective immediately, including mid-frame):
  - txd=1, tx_ready=1, tx_idle=1, tx_busy=0, fifo_count=0, overflow=0.
  - FIFO pointers are zeroed and the FSM goes to IDLE. The partially sent frame is abandoned, with no stop bit.
- FIFO is a circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - fifo_count is registered.
  - tx_ready and tx_idle are combinational from registered state only.
- Write: at an edge with wr_n==0 and fifo_count<FIFO_DEPTH, data_in is stored and the write pointer advances.
  - If fifo_count==FIFO_DEPTH, the byte is dropped and overflow is set, even if a pop occurs on the same edge.
- Pop: occurs when the FSM leaves IDLE or STOP with fifo_count>0. The head byte is loaded into the shift register.
- Simultaneous write and pop: both happen and fifo_count is unchanged.
- overflow: set by a dropped write, cleared by clr_ovf. If both happen on the same edge, set wins.
- FSM states and transitions:
  - IDLE: txd=1. If fifo_count>0: pop, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then, if fifo_count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: loads CLKS_PER_BIT-1 on each state or bit entry, decrements to 0; a bit ends on the edge where the counter is 0.
- txd is registered (glitch-free) and changes only on those edges.
- Latency:
  - A byte written at edge N into an empty FIFO with FSM IDLE is popped at edge N+1; txd falls after edge N+1.
  - The frame spans exactly 10*CLKS_PER_BIT cycles.
  - tx_idle rises after the final stop-bit edge if no further byte is queued.
- tx_busy is high in START, DATA and STOP.

Test Plan:
1. Hold reset low with stale FIFO contents, then release → txd=1, tx_ready=1, tx_idle=1, tx_busy=0, fifo_count=0, overflow=0; txd stays 1 with no writes.
2. CLKS_PER_BIT=4: write 0x55 at edge 0 → txd=0 for edges 1–4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1; tx_idle=1 after edge 41.
3. Write 0xA5 then 0x3C on consecutive edges → two contiguous 40-cycle frames; the second start bit follows the first stop bit with no gap; fifo_count sequence 1,1,0 after edges 0,1 and at the second pop.
4. FIFO_DEPTH=4: writes 0x01..0x06 on edges 0–5 → fifo_count after edges 0–4 is 1,1,2,3,4; tx_ready=0 after edge 4; 0x06 dropped, overflow=1; 0x01..0x05 transmitted in order.
5. Assert reset during DATA bit 3 of 0xF0 with 2 bytes queued → txd=1 immediately, fifo_count=0, overflow=0; a subsequent write of 0x81 yields a clean full frame.
6. Overflow set, then clr_ovf=1 on the same edge as a write to a full FIFO → overflow stays 1; clr_ovf alone on the next edge → overflow=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Captures bytes written by the CPU on the UART write strobe into
//            a circular FIFO and serialises them onto txd as 8N1 frames,
//            LSB first. Status lines are active-high so programs can poll
//            them through the jump-logic multiplexer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   i_clk      in   1      system clock, rising edge
//   reset      in   1      asynchronous active-low reset
//   data_in    in   8      byte to enqueue
//   wr_n       in   1      active-low write strobe, one byte per edge
//   clr_ovf    in   1      clears the sticky overflow flag
//   txd        out  1      serial output, idle high
//   tx_ready   out  1      FIFO not full
//   tx_idle    out  1      FIFO empty and transmitter idle
//   tx_busy    out  1      frame in progress
//   fifo_count out  CNT_W  queued bytes (excludes byte being shifted)
//   overflow   out  1      sticky, set when a write is dropped
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             wr_n,
  input  logic             clr_ovf,
  output logic             txd,
  output logic             tx_ready,
  output logic             tx_idle,
  output logic             tx_busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] C_BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_txd;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  // --------------------------------------------------------------------------
  // Combinational next-state values
  // --------------------------------------------------------------------------
  state_t            w_state_nxt;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        w_bit_idx_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_txd_nxt;
  logic              w_pop;

  logic              w_full;
  logic              w_not_empty;
  logic              w_wr_req;
  logic              w_wr_ok;
  logic              w_bit_end;
  logic [7:0]        w_head;

  assign w_full      = (r_count == C_DEPTH);
  assign w_not_empty = (r_count != '0);
  assign w_wr_req    = ~wr_n;
  // A write to a full FIFO is dropped even if a pop frees a slot on the same
  // edge; the capacity decision is made on the registered count only.
  assign w_wr_ok     = w_wr_req & ~w_full;
  assign w_bit_end   = (r_baud == '0);
  assign w_head      = r_mem[r_rptr];

  // --------------------------------------------------------------------------
  // FSM next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_txd_nxt     = r_txd;
    w_pop         = 1'b0;
    // Counter free-runs down and parks at zero; every state or bit entry
    // below reloads it, so a bit lasts exactly CLKS_PER_BIT edges.
    w_baud_nxt    = w_bit_end ? r_baud : (r_baud - 1'b1);

    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_baud_nxt  = C_BAUD_LOAD;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
          w_txd_nxt     = r_shift[0];
          w_baud_nxt    = C_BAUD_LOAD;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = C_BAUD_LOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            // Next bit on the line is shift[1]; drive it now so txd is
            // registered straight from the pre-shift value.
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_txd_nxt     = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          if (w_not_empty) begin
            // Back-to-back frames: skip IDLE so there is no gap.
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
            w_baud_nxt  = C_BAUD_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM / shifter registers. Reset abandons any frame in flight and forces
  // the line high immediately.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. Contents are not reset; pointers and count define validity.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_wr_req && w_full) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registered state only.
  // --------------------------------------------------------------------------
  assign txd        = r_txd;
  assign tx_ready   = (r_count < C_DEPTH);
  assign tx_idle    = (r_count == '0) && (r_state == S_IDLE);
  assign tx_busy    = (r_state != S_IDLE);
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire
